mux_sel_arbiter: RTL and testbench

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_arb_pkg.sv | 6 +
 rtl/mux_sel_arbiter_rr_pick.sv | 17 +
 rtl/mux_sel_arbiter.sv | 74 +++++++
 tb/tb_mux_sel_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and widths for the mux41 select arbiter.
package mux_arb_pkg;
  localparam int NUM_SRC = 4;
  localparam int SEL_W = 2;
  typedef enum logic [0:0] {IDLE, GRANT} state_e;
endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first set req bit from ptr upward.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   win
);
  always_comb begin
    found = |req;
    win = ptr;
    // walk downward so the candidate nearest to ptr overwrites the others
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req[ptr + SEL_W'(i)]) win = ptr + SEL_W'(i);
  end
endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin owner select for a downstream mux41, registered outputs.
// Define MUX_ARB_HOLD_LIMIT_EN to cap each owner at HOLD_MAX consecutive cycles.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic               switch_p
);
  state_e state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, win;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic valid_q, valid_d, switch_q, switch_d;
  logic found, other, at_limit, keep, new_g;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .win   (win)
  );

  assign other = |(req & ~grant_q);
  assign keep = (state_q == GRANT) && req[sel_q] && !(at_limit && other);
  assign new_g = found && !keep;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [3:0] hold_q, hold_d;
  assign at_limit = hold_q == 4'(HOLD_MAX);
  always_comb hold_d = new_g ? 4'd1 : keep ? (at_limit ? hold_q : hold_q + 4'd1) : 4'd0;
  always_ff @(posedge clk) hold_q <= !rst_n ? 4'd0 : hold_d;
`else
  // no limit without the counter; HOLD_MAX is legal only from 1 so this is constant 0
  assign at_limit = HOLD_MAX < 1;
`endif

  always_comb begin
    state_d = (keep || found) ? GRANT : IDLE;
    grant_d = keep ? grant_q : found ? NUM_SRC'(1) << win : '0;
    sel_d = new_g ? win : sel_q;
    ptr_d = new_g ? win + SEL_W'(1) : ptr_q;
    valid_d = keep || found;
    switch_d = new_g;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      sel_q <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      switch_q <= switch_d;
    end
  end

  assign grant = grant_q;
  assign sel = sel_q;
  assign valid = valid_q;
  assign switch_p = switch_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed and random scoreboard bench for mux_sel_arbiter.
module tb_mux_sel_arbiter;
  localparam int HOLD = 4;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       sw;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic valid, switch_p;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  int mptr = 0, mown = 0, mhold = 0;
  logic mval = 1'b0;

  mux_sel_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .valid    (valid),
    .switch_p (switch_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rn, input logic [3:0] eg,
                      input logic [1:0] es, input logic ev, input logic esw, input string tag);
    exp_t e;
    @(negedge clk);
    req = r;
    rst_n = rn;
    sb.push_back('{eg, es, ev, esw, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".grant"}, {4'b0, grant}, {4'b0, e.g});
    chk({e.tag, ".sel"}, {6'b0, sel}, {6'b0, e.s});
    chk({e.tag, ".valid"}, {7'b0, valid}, {7'b0, e.v});
    chk({e.tag, ".switch_p"}, {7'b0, switch_p}, {7'b0, e.sw});
  endtask

  task automatic model(input logic [3:0] r, output logic [3:0] eg, output logic [1:0] es,
                       output logic ev, output logic esw);
    logic rearb;
    rearb = !mval || !r[mown] || (HOLD_EN && mhold == HOLD && (r & ~(4'b1 << mown)) != 4'b0);
    esw = 1'b0;
    if (rearb) begin
      mval = 1'b0;
      mhold = 0;
      for (int j = 0; j < 4; j++)
        if (!mval && r[(mptr + j) % 4]) begin
          mown = (mptr + j) % 4;
          mval = 1'b1;
          esw = 1'b1;
          mhold = 1;
        end
      if (mval) mptr = (mown + 1) % 4;
    end else if (mhold < HOLD) mhold++;
    eg = mval ? 4'b1 << mown : 4'b0;
    es = 2'(mown);
    ev = mval;
  endtask

  initial begin
    logic [3:0] r, eg;
    logic [1:0] es;
    logic ev, esw;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    int wt[4];
    int worst = 0;
`endif
    // reset holds regardless of requests
    step(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rst0");
    step(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rst1");
    // single requester for three cycles, then idle with sel held
    step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, "r30_new");
    step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "r30_hold1");
    step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "r30_hold2");
    step(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "r30_idle");
    step(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "r30_idle2");
    // owner 1 drops with source 0 waiting: handoff without a bubble
    step(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, "r33_own1");
    step(4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "r33_keep");
    step(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, "r33_handoff");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "r33_idle");
    // reset during owner 3, then search restarts from source 0
    step(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, "r34_own3");
    step(4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, "r34_keep3");
    step(4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "r34_rst");
    step(4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, "r34_own1");
    step(4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "ptr_rst");
    step(4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, "ptr_from0");
    // chained handoffs in rotation order
    step(4'b1100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, "chain2");
    step(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, "chain3");
    step(4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, "chain_idle");
    // sole requester keeps the grant past any hold limit
    step(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, "solo_new");
    for (int c = 1; c < 8; c++)
      step(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("solo_%0d", c));
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "solo_idle");
    // all sources requesting continuously
    step(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "all_rst");
    for (int c = 0; c < 20; c++) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
      step(4'b1111, 1'b1, 4'b1 << ((c / HOLD) % 4), 2'((c / HOLD) % 4), 1'b1,
           (c % HOLD) == 0, $sformatf("all_%0d", c));
`else
      step(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, c == 0, $sformatf("all_%0d", c));
`endif
    end
    // random traffic against the reference model
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rnd_rst");
    mptr = 0;
    mown = 0;
    mhold = 0;
    mval = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      r = 4'($urandom_range(0, 15));
      model(r, eg, es, ev, esw);
      step(r, 1'b1, eg, es, ev, esw, $sformatf("rnd_%0d", c));
      chk("onehot0", 8'($onehot0(grant)), 8'd1);
      if (valid) chk("sel_vs_grant", {4'b0, grant}, {4'b0, 4'b1 << sel});
`ifdef MUX_ARB_HOLD_LIMIT_EN
      for (int i = 0; i < 4; i++) begin
        wt[i] = (req[i] && !grant[i]) ? wt[i] + 1 : 0;
        if (wt[i] > worst) worst = wt[i];
      end
`endif
    end
`ifdef MUX_ARB_HOLD_LIMIT_EN
    chk("wait_bound", 8'(worst <= 3 * HOLD + 3), 8'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
